// File: rtl/data_mem_responder.sv
// Memory-side load/store responder for a single-cycle RISC-V datapath: one request at a
// time, serviced against a word-organised RAM with a fixed wait-state latency.
module data_mem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_size,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [3:0] LAT = 4'(LATENCY);

   state_t                state, state_next;
   logic [3:0]            cnt, cnt_next;
   logic                  accept, enter_resp;
   logic [31:0]           addr_q, wdata_q;
   logic                  we_q;
   logic [2:0]            size_q;
   logic [31:0]           acc_addr, acc_wdata;
   logic                  acc_we;
   logic [2:0]            acc_size;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [1:0]            lane;
   logic                  acc_err;
   logic [3:0]            be;
   logic [31:0]           wlanes, rd_word, load_data;
   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [31:0]           mem [0:(1<<ADDR_WIDTH)-1];

   assign req_ready  = (state == IDLE) & ~rst;
   assign accept     = req_valid & req_ready;
   assign resp_valid = (state == RESP);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      enter_resp = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               cnt_next = LAT;
               if (LATENCY > 0) begin
                  state_next = WAIT;
               end else begin
                  state_next = RESP;
                  enter_resp = 1'b1;
               end
            end
         end
         WAIT: begin
            cnt_next = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_next = RESP;
               enter_resp = ~rst;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         we_q    <= req_we;
         size_q  <= req_size;
      end
   end

   // With zero latency the access happens on the accepting edge, so use the live request.
   assign acc_addr  = (state == IDLE) ? req_addr  : addr_q;
   assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
   assign acc_we    = (state == IDLE) ? req_we    : we_q;
   assign acc_size  = (state == IDLE) ? req_size  : size_q;

   assign word_idx = acc_addr[ADDR_WIDTH+1:2];
   assign lane     = acc_addr[1:0];

   always_comb begin
      acc_err = 1'b0;
      be      = 4'b0000;
      wlanes  = acc_wdata;
      case (acc_size)
         3'b000, 3'b100: begin
            be      = 4'b0001 << lane;
            wlanes  = {4{acc_wdata[7:0]}};
            acc_err = acc_we & acc_size[2];
         end
         3'b001, 3'b101: begin
            be      = lane[1] ? 4'b1100 : 4'b0011;
            wlanes  = {2{acc_wdata[15:0]}};
            acc_err = lane[0] | (acc_we & acc_size[2]);
         end
         3'b010: begin
            be      = 4'b1111;
            acc_err = (lane != 2'b00);
         end
         default: acc_err = 1'b1;
      endcase
      if (acc_addr[31:ADDR_WIDTH+2] != '0) acc_err = 1'b1;
   end

   assign rd_word = mem[word_idx];
   assign rd_byte = rd_word[{lane, 3'b000} +: 8];
   assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

   always_comb begin
      case (acc_size)
         3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
         3'b100:  load_data = {24'h0, rd_byte};
         3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
         3'b101:  load_data = {16'h0, rd_half};
         default: load_data = rd_word;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else if (enter_resp) begin
         resp_err   <= acc_err;
         resp_rdata <= (acc_err | acc_we) ? '0 : load_data;
      end
   end

   // NOTE: the RAM array has no reset; stored data must survive rst.
   always_ff @(posedge clk) begin
      if (enter_resp && acc_we && !acc_err) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: one LATENCY=2 and one LATENCY=0 instance,
// checked against a byte-array reference model of the RISC-V load/store rules.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        v2, v0, we;
   logic [31:0] addr, wdata;
   logic [2:0]  size;
   logic        rdy2, rv2, er2, rdy0, rv0, er0;
   logic [31:0] rd2, rd0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] ref_mem [2][4096];

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut2 (
      .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_we(we),
      .req_addr(addr), .req_wdata(wdata), .req_size(size),
      .resp_valid(rv2), .resp_rdata(rd2), .resp_err(er2)
   );

   data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(we),
      .req_addr(addr), .req_wdata(wdata), .req_size(size),
      .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Byte-level model: size -> byte count, alignment by modulo, range by byte limit.
   task automatic model(input int sel, input logic m_we, input logic [31:0] m_addr,
                        input logic [31:0] m_wdata, input logic [2:0] m_size,
                        output logic [31:0] m_rdata, output logic m_err);
      int nb;
      logic [31:0] v;
      case (m_size)
         3'd0, 3'd4: nb = 1;
         3'd1, 3'd5: nb = 2;
         3'd2:       nb = 4;
         default:    nb = 0;
      endcase
      m_err = (nb == 0) || (m_we && m_size[2]) || (m_addr >= 32'd4096) ||
              ((int'(m_addr[1:0]) % nb) != 0);
      m_rdata = 32'h0;
      if (!m_err) begin
         if (m_we) begin
            for (int i = 0; i < nb; i++) ref_mem[sel][int'(m_addr[11:0]) + i] = m_wdata[8*i +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v |= 32'(ref_mem[sel][int'(m_addr[11:0]) + i]) << (8*i);
            if (!m_size[2] && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8*nb);
            m_rdata = v;
         end
      end
   endtask

   // One complete transaction; called and returns at a falling edge.
   task automatic do_req(input int sel, input logic r_we, input logic [31:0] r_addr,
                         input logic [31:0] r_wdata, input logic [2:0] r_size, input string tag,
                         input bit use_exp = 1'b0, input logic [31:0] exp_d = 32'h0,
                         input logic exp_e = 1'b0);
      logic [31:0] md;
      logic        me;
      bit          got;
      int          n, lat;
      lat = (sel == 0) ? 2 : 0;
      model(sel, r_we, r_addr, r_wdata, r_size, md, me);
      if (use_exp) begin
         md = exp_d;
         me = exp_e;
      end
      we = r_we; addr = r_addr; wdata = r_wdata; size = r_size;
      if (sel == 0) v2 = 1'b1; else v0 = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         if ((sel == 0) ? rdy2 : rdy0) got = 1'b1;
         else @(negedge clk);
      end
      check({tag, " accept"}, 32'(got), 32'd1);
      @(posedge clk);
      @(negedge clk);
      v2 = 1'b0; v0 = 1'b0;
      got = 1'b0; n = 0;
      for (int t = 1; t <= 20 && !got; t++) begin
         if ((sel == 0) ? rv2 : rv0) begin
            got = 1'b1;
            n   = t;
         end else @(negedge clk);
      end
      check({tag, " resp_seen"}, 32'(got), 32'd1);
      check({tag, " latency"}, 32'(n), 32'(lat + 1));
      check({tag, " rdata"}, (sel == 0) ? rd2 : rd0, md);
      check({tag, " err"}, 32'((sel == 0) ? er2 : er0), 32'(me));
      @(negedge clk);
      check({tag, " one_cycle"}, 32'((sel == 0) ? rv2 : rv0), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] e1d, e2d, e3d, r_addr, r_data;
      logic        e1e, e2e, e3e, r_we;
      logic [2:0]  r_size;
      logic [2:0]  sizes [10];
      int          resp_cnt;
      sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7, 3'd2, 3'd2};

      rst = 1'b1; v2 = 1'b0; v0 = 1'b0; we = 1'b0; addr = '0; wdata = '0; size = '0;
      repeat (3) @(negedge clk);
      check("reset ready", 32'(rdy2), 32'd0);
      check("reset valid", 32'(rv2), 32'd0);
      check("reset rdata", rd2, 32'h0);
      check("reset err", 32'(er2), 32'd0);
      check("reset ready0", 32'(rdy0), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle ready", 32'(rdy2), 32'd1);

      // Basic word store/load
      do_req(0, 1'b1, 32'h0,  32'h1122_3344, 3'd2, "sw0");
      do_req(0, 1'b1, 32'h20, 32'h0BAD_C0DE, 3'd2, "sw20");
      do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'd2, "sw10", 1'b1, 32'h0, 1'b0);
      do_req(0, 1'b0, 32'h10, 32'h0, 3'd2, "lw10", 1'b1, 32'hDEAD_BEEF, 1'b0);

      // Byte lanes
      do_req(0, 1'b1, 32'h13, 32'h0000_00A5, 3'd0, "sb13");
      do_req(0, 1'b0, 32'h10, 32'h0, 3'd2, "lw10_b", 1'b1, 32'hA5AD_BEEF, 1'b0);
      do_req(0, 1'b0, 32'h13, 32'h0, 3'd0, "lb13",   1'b1, 32'hFFFF_FFA5, 1'b0);
      do_req(0, 1'b0, 32'h13, 32'h0, 3'd4, "lbu13",  1'b1, 32'h0000_00A5, 1'b0);
      do_req(0, 1'b0, 32'h10, 32'h0, 3'd0, "lb10",   1'b1, 32'hFFFF_FFEF, 1'b0);

      // Halfwords and misalignment
      do_req(0, 1'b1, 32'h12, 32'h0000_1234, 3'd1, "sh12");
      do_req(0, 1'b0, 32'h10, 32'h0, 3'd2, "lw10_h", 1'b1, 32'h1234_BEEF, 1'b0);
      do_req(0, 1'b0, 32'h10, 32'h0, 3'd5, "lhu10",  1'b1, 32'h0000_BEEF, 1'b0);
      do_req(0, 1'b0, 32'h10, 32'h0, 3'd1, "lh10",   1'b1, 32'hFFFF_BEEF, 1'b0);
      do_req(0, 1'b1, 32'h11, 32'h0000_5678, 3'd1, "sh11", 1'b1, 32'h0, 1'b1);
      do_req(0, 1'b0, 32'h10, 32'h0, 3'd2, "lw10_m", 1'b1, 32'h1234_BEEF, 1'b0);

      // Range and size errors
      do_req(0, 1'b1, 32'h0000_1000, 32'h1, 3'd2, "sw_oor", 1'b1, 32'h0, 1'b1);
      do_req(0, 1'b0, 32'h0, 32'h0, 3'd2, "lw0", 1'b1, 32'h1122_3344, 1'b0);
      do_req(0, 1'b0, 32'h0, 32'h0, 3'd3, "l_sz3", 1'b1, 32'h0, 1'b1);

      // Back-to-back: valid held across two requests
      do_req(0, 1'b1, 32'h44, 32'h4444_4444, 3'd2, "sw44");
      we = 1'b1; addr = 32'h40; wdata = 32'hA1B2_C3D4; size = 3'd2;
      model(0, we, addr, wdata, size, e1d, e1e);
      v2 = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check($sformatf("b2b ready k%0d", k), 32'(rdy2), 32'((k % 4) == 0));
         check($sformatf("b2b valid k%0d", k), 32'(rv2), 32'(k == 3 || k == 7));
         if (k == 3) begin
            check("b2b r1 rdata", rd2, e1d);
            check("b2b r1 err", 32'(er2), 32'(e1e));
         end
         if (k == 7) begin
            check("b2b r2 rdata", rd2, e2d);
            check("b2b r2 err", 32'(er2), 32'(e2e));
         end
         if (k == 1) begin
            we = 1'b0; addr = 32'h40; wdata = 32'h0; size = 3'd2;
            model(0, we, addr, wdata, size, e2d, e2e);
         end
         if (k == 5) v2 = 1'b0;
      end

      // Single-cycle pulse during WAIT is ignored
      we = 1'b0; addr = 32'h44; wdata = 32'h0; size = 3'd2;
      model(0, we, addr, wdata, size, e3d, e3e);
      v2 = 1'b1;
      @(posedge clk);
      resp_cnt = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (rv2) resp_cnt++;
         if (k == 3) check("pulse r1 rdata", rd2, e3d);
         v2 = 1'b0;
         if (k == 2) begin
            we = 1'b1; addr = 32'h44; wdata = 32'h5555_5555; size = 3'd2;
            v2 = 1'b1;
         end
      end
      check("pulse resp count", 32'(resp_cnt), 32'd1);
      do_req(0, 1'b0, 32'h44, 32'h0, 3'd2, "lw44", 1'b1, 32'h4444_4444, 1'b0);

      // Reset during WAIT abandons a store
      we = 1'b1; addr = 32'h20; wdata = 32'hCAFE_F00D; size = 3'd2;
      v2 = 1'b1;
      @(posedge clk);
      resp_cnt = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (rv2) resp_cnt++;
         if (k == 1) begin
            v2  = 1'b0;
            rst = 1'b1;
         end
         if (k == 2) begin
            check("rst ready low", 32'(rdy2), 32'd0);
            rst = 1'b0;
         end
      end
      check("rst no resp", 32'(resp_cnt), 32'd0);
      do_req(0, 1'b0, 32'h20, 32'h0, 3'd2, "lw20", 1'b1, 32'h0BAD_C0DE, 1'b0);

      // Zero-latency instance
      do_req(1, 1'b1, 32'h30, 32'h0123_4567, 3'd2, "l0 sw30");
      do_req(1, 1'b0, 32'h30, 32'h0, 3'd2, "l0 lw30", 1'b1, 32'h0123_4567, 1'b0);
      do_req(1, 1'b0, 32'h32, 32'h0, 3'd0, "l0 lb32", 1'b1, 32'h0000_0023, 1'b0);
      do_req(1, 1'b1, 32'h31, 32'h0, 3'd1, "l0 sh31", 1'b1, 32'h0, 1'b1);

      // Randomised traffic against the model
      for (int i = 0; i < 16; i++) do_req(0, 1'b1, 32'(i * 4), $urandom, 3'd2, "rnd init");
      for (int i = 0; i < 60; i++) begin
         r_we   = 1'($urandom_range(0, 1));
         r_addr = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 9) == 0) r_addr |= 32'h1000 << $urandom_range(0, 19);
         r_data = $urandom;
         r_size = sizes[$urandom_range(0, 9)];
         do_req(0, r_we, r_addr, r_data, r_size, $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
